// File: rtl/breakbeam_conditioner.sv
// Break-beam front end: 2-FF synchroniser, debounce FSM, retrigger holdoff and stall detect.
// Optional macro BREAKBEAM_GLITCH_CNT_EN enables the saturating rejected-break counter.
//
// state    | meaning
// CLEAR    | beam intact, break_clean=0, waiting for brk (and holdoff expired)
// CONF_BRK | brk seen, counting stable broken cycles before accepting
// BRK      | break accepted, break_clean=1
// CONF_CLR | brk dropped, counting stable clear cycles, break_clean still 1
module breakbeam_conditioner #(
  parameter int unsigned BEAM_ACTIVE_LOW = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLDOFF_CYCLES  = 500000,
  parameter int unsigned STALL_CYCLES    = 100000000,
  parameter int unsigned CNT_BITS        = 20,
  parameter int unsigned STALL_BITS      = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       beam_raw,
  output logic       break_clean,
  output logic       break_pulse,
  output logic       stalled,
  output logic [7:0] glitch_count
);

  localparam logic IDLE_LEVEL = (BEAM_ACTIVE_LOW != 0);
  localparam logic [CNT_BITS-1:0]   DEB_LAST   = CNT_BITS'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0]   HOLD_LOAD  = CNT_BITS'(HOLDOFF_CYCLES);
  localparam logic [STALL_BITS-1:0] STALL_MAX  = STALL_BITS'(STALL_CYCLES);
  localparam logic [STALL_BITS-1:0] STALL_PREV = STALL_BITS'(STALL_CYCLES - 1);

  typedef enum logic [1:0] {
    CLEAR    = 2'd0,
    CONF_BRK = 2'd1,
    BRK      = 2'd2,
    CONF_CLR = 2'd3
  } state_t;

  state_t                state;
  logic                  sync_1;
  logic                  sync_2;
  logic                  brk;
  logic                  accept;
  logic [CNT_BITS-1:0]   deb_cnt;
  logic [CNT_BITS-1:0]   hold_cnt;
  logic [STALL_BITS-1:0] stall_cnt;

  // The raw pin goes straight into the first flop; polarity is fixed up after the synchroniser.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1 <= IDLE_LEVEL;
      sync_2 <= IDLE_LEVEL;
    end else begin
      sync_1 <= beam_raw;
      sync_2 <= sync_1;
    end
  end

  assign brk    = sync_2 ^ IDLE_LEVEL;
  assign accept = (state == CONF_BRK) && brk && (deb_cnt == DEB_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= CLEAR;
      deb_cnt     <= '0;
      break_clean <= 1'b0;
      break_pulse <= 1'b0;
    end else begin
      break_pulse <= 1'b0;
      case (state)
        CLEAR: begin
          break_clean <= 1'b0;
          if ((hold_cnt == '0) && brk) begin
            state   <= CONF_BRK;
            deb_cnt <= CNT_BITS'(1);
          end
        end
        CONF_BRK: begin
          if (!brk) begin
            state <= CLEAR;
          end else if (deb_cnt == DEB_LAST) begin
            state       <= BRK;
            break_clean <= 1'b1;
            break_pulse <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + CNT_BITS'(1);
          end
        end
        BRK: begin
          break_clean <= 1'b1;
          if (!brk) begin
            state   <= CONF_CLR;
            deb_cnt <= CNT_BITS'(1);
          end
        end
        CONF_CLR: begin
          // A brief return of brk falls back to BRK without a new pulse.
          if (brk) begin
            state <= BRK;
          end else if (deb_cnt == DEB_LAST) begin
            state       <= CLEAR;
            break_clean <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + CNT_BITS'(1);
          end
        end
        default: begin
          state       <= CLEAR;
          break_clean <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
    end else if (accept) begin
      hold_cnt <= HOLD_LOAD;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - CNT_BITS'(1);
    end
  end

  // stalled is registered alongside the counter so it drops on the pulse edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      stalled   <= 1'b0;
    end else if (accept) begin
      stall_cnt <= '0;
      stalled   <= 1'b0;
    end else if (stall_cnt != STALL_MAX) begin
      stall_cnt <= stall_cnt + STALL_BITS'(1);
      stalled   <= (stall_cnt == STALL_PREV);
    end
  end

`ifdef BREAKBEAM_GLITCH_CNT_EN
  logic reject;
  assign reject = (state == CONF_BRK) && !brk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      glitch_count <= 8'd0;
    end else if (reject && (glitch_count != 8'hFF)) begin
      glitch_count <= glitch_count + 8'd1;
    end
  end
`else
  assign glitch_count = 8'd0;
`endif

endmodule

// File: tb/tb_breakbeam_conditioner.sv
// Self-checking bench for breakbeam_conditioner: directed scenarios plus random pin activity
// compared against a run-length reference model of the debounce/holdoff/stall rules.
module tb_breakbeam_conditioner;

  localparam int DEB   = 4;
  localparam int HOLD  = 20;
  localparam int STALL = 100;
`ifdef BREAKBEAM_GLITCH_CNT_EN
  localparam int GLITCH_ON = 1;
`else
  localparam int GLITCH_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       beam_raw = 1'b1;
  logic       break_clean;
  logic       break_pulse;
  logic       stalled;
  logic [7:0] glitch_count;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state; brk samples are 1 = broken
  logic m_d1, m_d2;
  logic m_clean, m_pulse, m_stalled;
  int   m_run, m_hold, m_since, m_glitch;

  breakbeam_conditioner #(
    .BEAM_ACTIVE_LOW(1),
    .DEBOUNCE_CYCLES(DEB),
    .HOLDOFF_CYCLES(HOLD),
    .STALL_CYCLES(STALL),
    .CNT_BITS(20),
    .STALL_BITS(28)
  ) dut (
    .clk(clk),
    .reset(reset),
    .beam_raw(beam_raw),
    .break_clean(break_clean),
    .break_pulse(break_pulse),
    .stalled(stalled),
    .glitch_count(glitch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_glitch();
    return (GLITCH_ON != 0) ? 8'(m_glitch) : 8'd0;
  endfunction

  task automatic model_reset();
    m_d1 = 1'b0; m_d2 = 1'b0;
    m_clean = 1'b0; m_pulse = 1'b0; m_stalled = 1'b0;
    m_run = 0; m_hold = 0; m_since = 0; m_glitch = 0;
  endtask

  // m_run = consecutive samples counted toward the pending level change
  task automatic model_edge(input logic pin);
    logic b;
    b = m_d2;
    m_d2 = m_d1;
    m_d1 = ~pin;
    m_pulse = 1'b0;
    if (!m_clean) begin
      if (b && (m_run > 0 || m_hold == 0)) begin
        m_run++;
        if (m_run == DEB) begin
          m_clean = 1'b1;
          m_pulse = 1'b1;
          m_run = 0;
        end
      end else begin
        if (m_run > 0 && m_glitch < 255) m_glitch++;
        m_run = 0;
      end
    end else begin
      if (!b) begin
        m_run++;
        if (m_run == DEB) begin
          m_clean = 1'b0;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    if (m_pulse) m_hold = HOLD;
    else if (m_hold > 0) m_hold--;
    if (m_pulse) m_since = 0;
    else if (m_since < STALL) m_since++;
    m_stalled = (m_since == STALL);
  endtask

  task automatic step(input logic pin);
    beam_raw = pin;
    @(posedge clk);
    model_edge(pin);
    #1;
    check("clean", {7'd0, break_clean}, {7'd0, m_clean});
    check("pulse", {7'd0, break_pulse}, {7'd0, m_pulse});
    check("stalled", {7'd0, stalled}, {7'd0, m_stalled});
    check("glitch", glitch_count, exp_glitch());
  endtask

  initial begin
    int second_at;
    int npulse;
    logic dropped;

    // reset state
    model_reset();
    #12;
    check("reset_clean", {7'd0, break_clean}, 8'd0);
    check("reset_pulse", {7'd0, break_pulse}, 8'd0);
    check("reset_stalled", {7'd0, stalled}, 8'd0);
    check("reset_glitch", glitch_count, 8'd0);
    reset = 1'b1;

    // idle: stall flag rises on the 100th cycle
    for (int k = 1; k <= 100; k++) begin
      step(1'b1);
      if (k == 99) check("stall_99", {7'd0, stalled}, 8'd0);
      if (k == 100) check("stall_100", {7'd0, stalled}, 8'd1);
    end

    // clean break: pulse exactly 6 clocks after the pin edge
    for (int k = 1; k <= 12; k++) begin
      step(1'b0);
      if (k == 5) check("brk_t5_clean", {7'd0, break_clean}, 8'd0);
      if (k == 5) check("brk_t5_pulse", {7'd0, break_pulse}, 8'd0);
      if (k == 6) check("brk_t6_clean", {7'd0, break_clean}, 8'd1);
      if (k == 6) check("brk_t6_pulse", {7'd0, break_pulse}, 8'd1);
      if (k == 6) check("brk_t6_stall", {7'd0, stalled}, 8'd0);
      if (k == 7) check("brk_t7_pulse", {7'd0, break_pulse}, 8'd0);
    end
    // release: clean falls 6 clocks later, no pulse
    for (int k = 1; k <= 30; k++) begin
      step(1'b1);
      if (k == 5) check("clr_t5_clean", {7'd0, break_clean}, 8'd1);
      if (k == 6) check("clr_t6_clean", {7'd0, break_clean}, 8'd0);
      if (k == 6) check("clr_t6_pulse", {7'd0, break_pulse}, 8'd0);
    end

    // holdoff: re-break 8 cycles after the pulse, accepted only at pulse+24
    for (int k = 1; k <= 6; k++) step(1'b0);
    check("hold_first_pulse", {7'd0, break_pulse}, 8'd1);
    for (int k = 1; k <= 7; k++) step(1'b1);
    second_at = 0;
    for (int k = 8; k <= 40; k++) begin
      step(1'b0);
      if (break_pulse && second_at == 0) second_at = k;
    end
    check("hold_second_at", 8'(second_at), 8'd24);
    check("hold_glitch", glitch_count, 8'd0);
    for (int k = 1; k <= 25; k++) step(1'b1);

    // short low pulses are rejected and counted
    step(1'b0); step(1'b0);
    for (int k = 1; k <= 3; k++) step(1'b1);
    check("glitch_one", glitch_count, 8'(GLITCH_ON));
    check("glitch_one_clean", {7'd0, break_clean}, 8'd0);
    for (int n = 2; n <= 300; n++) begin
      step(1'b0); step(1'b0);
      for (int k = 1; k <= 3; k++) step(1'b1);
    end
    check("glitch_sat", glitch_count, (GLITCH_ON != 0) ? 8'd255 : 8'd0);

    // asynchronous reset in the middle of confirmation
    for (int k = 1; k <= 3; k++) step(1'b0);
    check("pre_rst_stall", {7'd0, stalled}, 8'd1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("arst_clean", {7'd0, break_clean}, 8'd0);
    check("arst_pulse", {7'd0, break_pulse}, 8'd0);
    check("arst_stalled", {7'd0, stalled}, 8'd0);
    check("arst_glitch", glitch_count, 8'd0);
    #2 reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1'b0);
      if (k == 5) check("arst_t5_pulse", {7'd0, break_pulse}, 8'd0);
      if (k == 6) check("arst_t6_pulse", {7'd0, break_pulse}, 8'd1);
    end
    for (int k = 1; k <= 25; k++) step(1'b1);

    // one-cycle high glitch inside an accepted break
    npulse = 0;
    dropped = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step((k == 6) ? 1'b1 : 1'b0);
      if (break_pulse) npulse++;
      if (k >= 6 && !break_clean) dropped = 1'b1;
    end
    check("inbrk_pulses", 8'(npulse), 8'd1);
    check("inbrk_dropped", {7'd0, dropped}, 8'd0);
    for (int k = 1; k <= 25; k++) step(1'b1);

    // random runs of pin activity against the model
    for (int n = 0; n < 400; n++) begin
      logic lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30)) : int'($urandom_range(1, 6));
      for (int k = 0; k < len; k++) step(lvl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
